// File: rtl/des_perm_engine.sv
// -----------------------------------------------------------------------------
// des_perm_engine
//   Sequential DES bit-permutation engine. Applies either the initial
//   permutation (IP) or the final permutation (IP^-1) to one 64-bit block,
//   producing LANES output bits per clock. One block is in flight at a time,
//   with valid/ready handshakes on both sides.
//
//   Bit ordering: bit 0 of every 64-bit vector is DES bit 1 (the MSB).
//
// Parameters
//   LANES      output bits written per clock; power of two in 1..64
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   block offered on in_data/in_mode
//   in_ready   engine accepts a block this cycle (combinational)
//   in_data    64-bit input block
//   in_mode    0 = IP, 1 = IP^-1
//   out_valid  out_data holds a finished block
//   out_ready  consumer takes the block
//   out_data   permuted block
//   busy       engine is producing chunks
// -----------------------------------------------------------------------------
module des_perm_engine #(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_data,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_data,
  output logic        busy
);

  localparam int NCHUNK = 64 / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Reject lane counts that do not divide the block into equal power-of-two chunks.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
        LANES == 16 || LANES == 32 || LANES == 64)) begin : g_lanes_check
    $error("des_perm_engine: LANES must be one of 1,2,4,8,16,32,64");
  end

  // Source index of output bit i under IP (i = 8r + c).
  function automatic int ip_src(input int i);
    int r;
    int c;
    r = i / 8;
    c = i % 8;
    if (r < 4) begin
      return 8 * (7 - c) + (2 * r + 1);
    end else begin
      return 8 * (7 - c) + (2 * (r - 4));
    end
  endfunction

  // Source index of output bit i under IP^-1 (i = 8r + c).
  function automatic int fp_src(input int i);
    int r;
    int c;
    r = i / 8;
    c = i % 8;
    if ((c % 2) == 1) begin
      return 8 * (c / 2) + 7 - r;
    end else begin
      return 8 * (c / 2) + 39 - r;
    end
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [0:63]      r_src;
  logic             r_mode;
  logic [0:63]      r_out_data;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;
  logic [0:63]      w_perm_ip;
  logic [0:63]      w_perm_fp;
  logic [0:63]      w_perm;

  // Both permutations are pure wiring from the latched source block.
  for (genvar gi = 0; gi < 64; gi++) begin : g_map
    localparam int IP_S = ip_src(gi);
    localparam int FP_S = fp_src(gi);
    assign w_perm_ip[gi] = r_src[IP_S];
    assign w_perm_fp[gi] = r_src[FP_S];
  end

  assign w_perm   = r_mode ? w_perm_fp : w_perm_ip;
  assign w_last   = (r_count == LAST_CNT);
  assign w_accept = in_valid & w_in_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        // A new block may be taken on the same edge the old one is consumed.
        if (out_ready && in_valid) begin
          w_state_nxt = S_BUSY;
        end else if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: in_ready is combinational, the flags are registered from the next state.
  always_comb begin
    w_in_ready      = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
      end
      S_BUSY: begin
        w_in_ready = 1'b0;
      end
      S_DONE: begin
        w_in_ready = out_ready;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt == S_BUSY);
  end

  // Source block, mode and chunk counter; source and mode move only on an accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src   <= 64'd0;
      r_mode  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_src   <= in_data;
      r_mode  <= in_mode;
      r_count <= '0;
    end else if (r_state == S_BUSY) begin
      r_src   <= r_src;
      r_mode  <= r_mode;
      if (w_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + ONE_CNT;
      end
    end else begin
      r_src   <= r_src;
      r_mode  <= r_mode;
      r_count <= r_count;
    end
  end

  // Output block: one LANES-wide chunk per BUSY cycle, ascending bit order.
  // Chunks not yet written keep the previous block's bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data <= 64'd0;
    end else if (r_state == S_BUSY) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (r_count == CNT_W'(k)) begin
          r_out_data[k*LANES +: LANES] <= w_perm[k*LANES +: LANES];
        end
      end
    end else begin
      r_out_data <= r_out_data;
    end
  end

  // Registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_des_perm_engine.sv
// -----------------------------------------------------------------------------
// tb_des_perm_engine
//   Directed self-checking bench. The LANES=8 instance carries the main
//   scenarios; LANES=1 and LANES=64 instances share in_data/in_mode and have
//   their own handshake lines for the walking-one sweep. Expected values come
//   from the standard DES IP / IP^-1 tables held in the bench.
// -----------------------------------------------------------------------------
module tb_des_perm_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:63] in_data;
  logic        in_mode;

  logic        in_valid, out_ready;
  logic        in_ready_8, out_valid_8, busy_8;
  logic [0:63] out_data_8;

  logic        in_valid_x, out_ready_x;
  logic        in_ready_1, out_valid_1, busy_1;
  logic [0:63] out_data_1;
  logic        in_ready_64, out_valid_64, busy_64;
  logic [0:63] out_data_64;

  int n_pass  = 0;
  int n_total = 0;

  // Standard DES tables, 1-based source bit numbers.
  int ip_tab [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_tab [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  des_perm_engine #(.LANES(8)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_8),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid_8), .out_ready(out_ready),
    .out_data(out_data_8), .busy(busy_8));

  des_perm_engine #(.LANES(1)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_x), .in_ready(in_ready_1),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid_1), .out_ready(out_ready_x),
    .out_data(out_data_1), .busy(busy_1));

  des_perm_engine #(.LANES(64)) u64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_x), .in_ready(in_ready_64),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid_64), .out_ready(out_ready_x),
    .out_data(out_data_64), .busy(busy_64));

  always #5 clk = ~clk;

  function automatic logic [0:63] model(input logic [0:63] x, input logic m);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) begin
      if (m) y[i] = x[fp_tab[i] - 1];
      else   y[i] = x[ip_tab[i] - 1];
    end
    return y;
  endfunction

  // Stimulus helper for u8: offer one block, wait (bounded) for out_valid,
  // return the result and latency, then consume it.
  task automatic do_block(input logic [0:63] d, input logic m,
                          output logic [0:63] res, output int lat);
    in_data   = d;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out_valid_8 ? out_data_8 : 64'bx;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (in_ready_8 !== 1'b1 || out_valid_8 !== 1'b0 || busy_8 !== 1'b0 || out_data_8 !== 64'd0) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0000000000000000",
               in_ready_8, out_valid_8, busy_8, out_data_8);
    end else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready_8 !== 1'b1 || out_valid_8 !== 1'b0) begin
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready_8, out_valid_8);
    end else n_pass++;
  endtask

  task automatic test_ip_vector();
    logic [0:63] res;
    int lat;
    in_data   = 64'h0123456789ABCDEF;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (busy_8 !== 1'b1 || in_ready_8 !== 1'b0) begin
      $display("FAIL ip_busy: busy=%b in_ready=%b, required 1 0", busy_8, in_ready_8);
    end else n_pass++;
    lat = 0;
    while (!out_valid_8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat !== 8) begin
      $display("FAIL ip_latency: got %0d cycles, required 8", lat);
    end else n_pass++;
    res = out_data_8;
    n_total++;
    if (res !== 64'hCC00CCFFF0AAF0AA) begin
      $display("FAIL ip_vector: got %h, required cc00ccfff0aaf0aa", res);
    end else n_pass++;
    n_total++;
    if (busy_8 !== 1'b0) begin
      $display("FAIL ip_done_busy: busy=%b, required 0", busy_8);
    end else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid_8 !== 1'b0 || in_ready_8 !== 1'b1) begin
      $display("FAIL ip_drain: out_valid=%b in_ready=%b, required 0 1", out_valid_8, in_ready_8);
    end else n_pass++;
  endtask

  task automatic test_fp_vector();
    logic [0:63] res;
    int lat;
    do_block(64'hCC00CCFFF0AAF0AA, 1'b1, res, lat);
    n_total++;
    if (res !== 64'h0123456789ABCDEF || lat !== 8) begin
      $display("FAIL fp_vector: got %h lat %0d, required 0123456789abcdef lat 8", res, lat);
    end else n_pass++;
  endtask

  task automatic test_roundtrip();
    logic [0:63] d, a, b;
    int lat;
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom};
      do_block(d, 1'b0, a, lat);
      do_block(a, 1'b1, b, lat);
      n_total++;
      if (a !== model(d, 1'b0)) begin
        if (bad < 10) $display("FAIL roundtrip_ip: in %h got %h, required %h", d, a, model(d, 1'b0));
        bad++;
      end else n_pass++;
      n_total++;
      if (b !== d) begin
        if (bad < 10) $display("FAIL roundtrip_back: got %h, required %h", b, d);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_walk();
    logic [0:63] d, res, r1, r64;
    int lat, cyc, l1, l64;
    bit got1, got64;
    int bad = 0;
    // Named single-bit vectors.
    do_block(64'h8000000000000000, 1'b0, res, lat);
    n_total++;
    if (res !== 64'h0000000001000000) begin
      $display("FAIL walk_bit0_ip: got %h, required 0000000001000000", res);
    end else n_pass++;
    do_block(64'h8000000000000000, 1'b1, res, lat);
    n_total++;
    if (res !== 64'h0000000000000040) begin
      $display("FAIL walk_bit0_fp: got %h, required 0000000000000040", res);
    end else n_pass++;
    out_ready_x = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 64; b++) begin
        d = 64'd0;
        d[b] = 1'b1;
        do_block(d, m[0], res, lat);
        n_total++;
        if (res !== model(d, m[0])) begin
          if (bad < 10) $display("FAIL walk_l8: mode %0d bit %0d got %h, required %h", m, b, res, model(d, m[0]));
          bad++;
        end else n_pass++;
        in_data    = d;
        in_mode    = m[0];
        in_valid_x = 1'b1;
        @(negedge clk);
        in_valid_x = 1'b0;
        got1 = 1'b0; got64 = 1'b0; r1 = 64'bx; r64 = 64'bx; l1 = -1; l64 = -1;
        cyc = 0;
        while (!(got1 && got64) && cyc < 100) begin
          if (out_valid_1 && !got1) begin got1 = 1'b1; r1 = out_data_1; l1 = cyc; end
          if (out_valid_64 && !got64) begin got64 = 1'b1; r64 = out_data_64; l64 = cyc; end
          @(negedge clk);
          cyc++;
        end
        n_total++;
        if (r1 !== model(d, m[0]) || l1 !== 64) begin
          if (bad < 10) $display("FAIL walk_l1: mode %0d bit %0d got %h lat %0d, required %h lat 64", m, b, r1, l1, model(d, m[0]));
          bad++;
        end else n_pass++;
        n_total++;
        if (r64 !== model(d, m[0]) || l64 !== 1) begin
          if (bad < 10) $display("FAIL walk_l64: mode %0d bit %0d got %h lat %0d, required %h lat 1", m, b, r64, l64, model(d, m[0]));
          bad++;
        end else n_pass++;
      end
    end
    out_ready_x = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [0:63] a, bb, exp_a, exp_b;
    int lat;
    a  = 64'h0123456789ABCDEF;
    bb = 64'h133457799BBCDFF1;
    exp_a = model(a, 1'b0);
    exp_b = model(bb, 1'b1);
    in_data = a; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    // Offer the next block while the consumer stalls.
    in_data = bb; in_mode = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++;
      if (out_valid_8 !== 1'b1 || out_data_8 !== exp_a || in_ready_8 !== 1'b0) begin
        $display("FAIL bp_hold: cycle %0d out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                 k, out_valid_8, out_data_8, in_ready_8, exp_a);
      end else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready_8 !== 1'b1) begin
      $display("FAIL bp_in_ready: got %b, required 1", in_ready_8);
    end else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_total++;
    if (out_valid_8 !== 1'b0 || busy_8 !== 1'b1) begin
      $display("FAIL bp_b2b_accept: out_valid=%b busy=%b, required 0 1", out_valid_8, busy_8);
    end else n_pass++;
    lat = 0;
    while (!out_valid_8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (out_data_8 !== exp_b || lat !== 8) begin
      $display("FAIL bp_second_block: got %h lat %0d, required %h lat 8", out_data_8, lat, exp_b);
    end else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic [0:63] res;
    int lat;
    in_data = 64'hFEDCBA9876543210; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy_8 !== 1'b1) begin
      $display("FAIL rst_busy_pre: busy=%b, required 1", busy_8);
    end else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (out_valid_8 !== 1'b0 || out_data_8 !== 64'd0 || in_ready_8 !== 1'b1 || busy_8 !== 1'b0) begin
      $display("FAIL rst_busy_async: out_valid=%b out_data=%h in_ready=%b busy=%b, required 0 0000000000000000 1 0",
               out_valid_8, out_data_8, in_ready_8, busy_8);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid_8 !== 1'b0 || out_data_8 !== 64'd0 || in_ready_8 !== 1'b1) begin
      $display("FAIL rst_busy_edge: out_valid=%b out_data=%h in_ready=%b, required 0 0000000000000000 1",
               out_valid_8, out_data_8, in_ready_8);
    end else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    do_block(64'h0F1E2D3C4B5A6978, 1'b1, res, lat);
    n_total++;
    if (res !== model(64'h0F1E2D3C4B5A6978, 1'b1) || lat !== 8) begin
      $display("FAIL rst_busy_next: got %h lat %0d, required %h lat 8", res, lat, model(64'h0F1E2D3C4B5A6978, 1'b1));
    end else n_pass++;
  endtask

  task automatic test_ignore_midblock();
    logic [0:63] e;
    int lat;
    e = 64'hA5A5F00F3C3C1234;
    in_data = e; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_data = ~e; in_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_data = {$urandom, $urandom};
      n_total++;
      if (in_ready_8 !== 1'b0) begin
        $display("FAIL ign_in_ready: cycle %0d got %b, required 0", k, in_ready_8);
      end else n_pass++;
    end
    lat = 0;
    while (!out_valid_8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    n_total++;
    if (out_data_8 !== model(e, 1'b0) || out_valid_8 !== 1'b1) begin
      $display("FAIL ign_result: got %h valid %b, required %h valid 1", out_data_8, out_valid_8, model(e, 1'b0));
    end else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_x = 1'b0; out_ready_x = 1'b0;
    in_data = 64'd0; in_mode = 1'b0;
    test_reset();
    test_ip_vector();
    test_fp_vector();
    test_walk();
    test_backpressure();
    test_reset_busy();
    test_ignore_midblock();
    test_roundtrip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
